// File: rtl/traffic_pkg.sv
// Shared types for the intersection light monitor: decoded phases, fault causes,
// lamp encodings and the legal phase-transition table.
package traffic_pkg;

   typedef enum logic [2:0] {
      P_UNSYNC = 3'd0,
      P_MG     = 3'd1,
      P_MY     = 3'd2,
      P_SG     = 3'd3,
      P_SY     = 3'd4,
      P_PG     = 3'd5,
      P_AR     = 3'd6
   } phase_t;

   typedef enum logic [2:0] {
      F_NONE     = 3'd0,
      F_CONFLICT = 3'd1,
      F_SEQ      = 3'd2,
      F_SHORT_Y  = 3'd3,
      F_STUCK    = 3'd4
   } fault_t;

   localparam logic [2:0] RED  = 3'b100;
   localparam logic [2:0] YEL  = 3'b010;
   localparam logic [2:0] GRN  = 3'b001;
   localparam logic [1:0] PRED = 2'b10;
   localparam logic [1:0] PGRN = 2'b01;

   function automatic logic legal_trans(input phase_t from_p, input phase_t to_p);
      logic ok;
      ok = 1'b0;
      case (from_p)
         P_AR:    ok = (to_p == P_MG);
         P_MG:    ok = (to_p == P_MY);
         P_MY:    ok = (to_p == P_SG);
         P_SG:    ok = (to_p == P_SY);
         P_SY:    ok = (to_p == P_MG) || (to_p == P_PG);
         P_PG:    ok = (to_p == P_AR);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic is_yellow(input phase_t p);
      return (p == P_MY) || (p == P_SY);
   endfunction

endpackage

// File: rtl/light_pattern_decoder.sv
// Combinational decode of the synchronized {main, sec, pea} lamp vector into a
// phase; anything outside the six known patterns is flagged as not legal.
module light_pattern_decoder
   import traffic_pkg::*;
(
   input  logic [7:0] v,
   output logic       legal,
   output logic [2:0] phase
);

   always_comb begin
      legal = 1'b1;
      phase = P_UNSYNC;
      case (v)
         {GRN, RED, PRED}: phase = P_MG;
         {YEL, RED, PRED}: phase = P_MY;
         {RED, GRN, PRED}: phase = P_SG;
         {RED, YEL, PRED}: phase = P_SY;
         {RED, RED, PGRN}: phase = P_PG;
         {RED, RED, PRED}: phase = P_AR;
         default:          legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Independent safety monitor on the controller's lamp outputs: tracks the phase,
// times it, latches the first conflict/sequence/timing fault and drives a 1 Hz flash.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int FPGAFREQ     = 50_000_000,
   parameter int T_MIN_YELLOW = 3,
   parameter int T_MAX_PHASE  = 30,
   localparam int SW          = $clog2(T_MAX_PHASE + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    main_lights,
   input  logic [2:0]    sec_lights,
   input  logic [1:0]    pea_lights,
   input  logic          fault_clear,
   output logic [2:0]    phase_id,
   output logic [SW-1:0] sec_in_phase,
   output logic          fault,
   output logic [2:0]    fault_code,
   output logic          flash_en
);

   localparam int DW   = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
   localparam int HALF = (FPGAFREQ / 2 > 0) ? FPGAFREQ / 2 : 1;
   localparam int FW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [7:0]    s1_q, s1_d, s2_q, s2_d;
   logic [1:0]    arm_q, arm_d;
   phase_t        phase_q, phase_d;
   logic [DW-1:0] div_q, div_d;
   logic [SW-1:0] sec_q, sec_d;
   logic          fault_q, fault_d;
   fault_t        code_q, code_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          flash_q, flash_d;

   logic          dec_legal;
   logic [2:0]    dec_phase_raw;
   phase_t        dec_phase;
   logic          armed, phase_chg, tick;
   logic          conflict, seq_err, short_y, stuck;
   logic          clear_ok, latch;
   fault_t        new_code;

   light_pattern_decoder u_dec (
      .v     (s2_q),
      .legal (dec_legal),
      .phase (dec_phase_raw)
   );

   assign dec_phase = phase_t'(dec_phase_raw);

   always_comb begin
      s1_d  = {main_lights, sec_lights, pea_lights};
      s2_d  = s1_q;
      // Checks stay off until the synchronizer holds real samples, not reset zeros.
      arm_d = {arm_q[0], 1'b1};
      armed = arm_q[1];

      phase_chg = armed && dec_legal && (dec_phase != phase_q);
      tick      = (div_q == DW'(FPGAFREQ - 1));

      conflict = armed && !dec_legal;
      seq_err  = phase_chg && (phase_q != P_UNSYNC) && !legal_trans(phase_q, dec_phase);
      short_y  = phase_chg && is_yellow(phase_q) && (sec_q < SW'(T_MIN_YELLOW));
      stuck    = !phase_chg && (phase_q != P_UNSYNC) && tick && (sec_q == SW'(T_MAX_PHASE - 1));

      phase_d = phase_q;
      div_d   = div_q;
      sec_d   = sec_q;
      if (phase_chg) begin
         phase_d = dec_phase;
         div_d   = '0;
         sec_d   = '0;
      end else if (phase_q != P_UNSYNC) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick && (sec_q != SW'(T_MAX_PHASE)))
            sec_d = sec_q + 1'b1;
      end

      if (conflict)      new_code = F_CONFLICT;
      else if (seq_err)  new_code = F_SEQ;
      else if (short_y)  new_code = F_SHORT_Y;
      else if (stuck)    new_code = F_STUCK;
      else               new_code = F_NONE;

      // A clear cycle that also sees a new fault re-latches the new cause.
      clear_ok = fault_q && fault_clear && (phase_q == P_AR);
      latch    = (new_code != F_NONE) && (!fault_q || clear_ok);

      fault_d = fault_q;
      code_d  = code_q;
      if (latch) begin
         fault_d = 1'b1;
         code_d  = new_code;
      end else if (clear_ok) begin
         fault_d = 1'b0;
         code_d  = F_NONE;
      end

      fcnt_d  = fcnt_q;
      flash_d = flash_q;
      if (latch || !fault_d) begin
         fcnt_d  = '0;
         flash_d = 1'b0;
      end else if (fcnt_q == FW'(HALF - 1)) begin
         fcnt_d  = '0;
         flash_d = !flash_q;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         arm_q   <= '0;
         phase_q <= P_UNSYNC;
         div_q   <= '0;
         sec_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= F_NONE;
         fcnt_q  <= '0;
         flash_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         arm_q   <= arm_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         sec_q   <= sec_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         fcnt_q  <= fcnt_d;
         flash_q <= flash_d;
      end
   end

   assign phase_id     = phase_q;
   assign sec_in_phase = sec_q;
   assign fault        = fault_q;
   assign fault_code   = code_q;
   assign flash_en     = flash_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scenario bench for traffic_light_monitor at FPGAFREQ=8, T_MIN_YELLOW=2,
// T_MAX_PHASE=10; expected phase/fault results are queued at drive time.
module tb_traffic_light_monitor;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] main_lights, sec_lights;
   logic [1:0] pea_lights;
   logic       fault_clear;
   logic [2:0] phase_id;
   logic [3:0] sec_in_phase;
   logic       fault;
   logic [2:0] fault_code;
   logic       flash_en;

   typedef struct {
      logic [2:0] ph;
      logic       flt;
      logic [2:0] code;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   traffic_light_monitor #(.FPGAFREQ(8), .T_MIN_YELLOW(2), .T_MAX_PHASE(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .main_lights  (main_lights),
      .sec_lights   (sec_lights),
      .pea_lights   (pea_lights),
      .fault_clear  (fault_clear),
      .phase_id     (phase_id),
      .sec_in_phase (sec_in_phase),
      .fault        (fault),
      .fault_code   (fault_code),
      .flash_en     (flash_en)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_lights(input logic [2:0] m, input logic [2:0] s, input logic [1:0] p);
      main_lights = m;
      sec_lights  = s;
      pea_lights  = p;
   endtask

   // Stimulus-only return to a clean all-red state after a latched fault.
   task automatic recover();
      set_lights(RED, RED, PRED);
      step(3);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      fault_clear = 1'b0;
      set_lights(RED, RED, PRED);
      step(2);
      total++; if (phase_id !== P_UNSYNC) begin bad++; $display("FAIL rst_phase: got %0d want %0d", phase_id, P_UNSYNC); end
      total++; if (sec_in_phase !== 4'd0) begin bad++; $display("FAIL rst_sec: got %0d want 0", sec_in_phase); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %0b want 0", fault); end
      total++; if (fault_code !== F_NONE) begin bad++; $display("FAIL rst_code: got %0d want 0", fault_code); end
      total++; if (flash_en !== 1'b0) begin bad++; $display("FAIL rst_flash: got %0b want 0", flash_en); end
      reset = 1'b0;
      sb.push_back('{ph: P_AR, flt: 1'b0, code: F_NONE});
      step(3);
      e = sb.pop_front();
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL first_ar: got %0d want %0d", phase_id, e.ph); end
      total++; if (fault !== e.flt) begin bad++; $display("FAIL first_ar_fault: got %0b want %0b", fault, e.flt); end
      step(21);
      total++; if (sec_in_phase !== 4'd2) begin bad++; $display("FAIL ar_sec: got %0d want 2", sec_in_phase); end
   endtask

   task automatic test_legal_cycle();
      logic [2:0] mt [6] = '{GRN, YEL, RED, RED, RED, RED};
      logic [2:0] st [6] = '{RED, RED, GRN, YEL, RED, RED};
      logic [1:0] pt [6] = '{PRED, PRED, PRED, PRED, PGRN, PRED};
      logic [2:0] ph [6] = '{P_MG, P_MY, P_SG, P_SY, P_PG, P_AR};
      logic [2:0] prev;
      exp_t e;
      prev = P_AR;
      for (int i = 0; i < 6; i++) begin
         set_lights(mt[i], st[i], pt[i]);
         sb.push_back('{ph: ph[i], flt: 1'b0, code: F_NONE});
         step(2);
         total++; if (phase_id !== prev) begin bad++; $display("FAIL legal_latency%0d: got %0d want %0d", i, phase_id, prev); end
         step(1);
         e = sb.pop_front();
         total++; if (phase_id !== e.ph) begin bad++; $display("FAIL legal_phase%0d: got %0d want %0d", i, phase_id, e.ph); end
         total++; if (fault !== e.flt) begin bad++; $display("FAIL legal_fault%0d: got %0b want %0b", i, fault, e.flt); end
         step(21);
         total++; if (sec_in_phase !== 4'd2) begin bad++; $display("FAIL legal_sec%0d: got %0d want 2", i, sec_in_phase); end
         prev = ph[i];
      end
   endtask

   task automatic test_conflict();
      exp_t e;
      set_lights(GRN, RED, PRED);
      step(3);
      total++; if (phase_id !== P_MG) begin bad++; $display("FAIL conf_pre: got %0d want %0d", phase_id, P_MG); end
      set_lights(GRN, GRN, PRED);
      sb.push_back('{ph: P_MG, flt: 1'b1, code: F_CONFLICT});
      step(2);
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL conf_early: got %0b want 0", fault); end
      step(1);
      e = sb.pop_front();
      total++; if (fault !== e.flt) begin bad++; $display("FAIL conf_fault: got %0b want %0b", fault, e.flt); end
      total++; if (fault_code !== e.code) begin bad++; $display("FAIL conf_code: got %0d want %0d", fault_code, e.code); end
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL conf_hold: got %0d want %0d", phase_id, e.ph); end
      total++; if (flash_en !== 1'b0) begin bad++; $display("FAIL flash_l0: got %0b want 0", flash_en); end
      step(3);
      total++; if (flash_en !== 1'b0) begin bad++; $display("FAIL flash_l3: got %0b want 0", flash_en); end
      step(1);
      total++; if (flash_en !== 1'b1) begin bad++; $display("FAIL flash_l4: got %0b want 1", flash_en); end
      step(4);
      total++; if (flash_en !== 1'b0) begin bad++; $display("FAIL flash_l8: got %0b want 0", flash_en); end
      recover();
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL conf_clear: got %0b want 0", fault); end
   endtask

   task automatic test_bad_seq();
      exp_t e;
      set_lights(GRN, RED, PRED);
      step(3);
      set_lights(RED, GRN, PRED);
      sb.push_back('{ph: P_SG, flt: 1'b1, code: F_SEQ});
      step(3);
      e = sb.pop_front();
      total++; if (fault_code !== e.code) begin bad++; $display("FAIL seq_code: got %0d want %0d", fault_code, e.code); end
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL seq_phase: got %0d want %0d", phase_id, e.ph); end
      recover();
   endtask

   task automatic test_short_yellow();
      exp_t e;
      set_lights(GRN, RED, PRED);
      step(3);
      set_lights(YEL, RED, PRED);
      step(3);
      step(8);
      total++; if (sec_in_phase !== 4'd1) begin bad++; $display("FAIL sy_sec: got %0d want 1", sec_in_phase); end
      set_lights(RED, GRN, PRED);
      sb.push_back('{ph: P_SG, flt: 1'b1, code: F_SHORT_Y});
      step(3);
      e = sb.pop_front();
      total++; if (fault_code !== e.code) begin bad++; $display("FAIL sy_code: got %0d want %0d", fault_code, e.code); end
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL sy_phase: got %0d want %0d", phase_id, e.ph); end
      fault_clear = 1'b1;
      step(2);
      fault_clear = 1'b0;
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL sy_clr_ignored: got %0b want 1", fault); end
      total++; if (fault_code !== F_SHORT_Y) begin bad++; $display("FAIL sy_code_frozen: got %0d want 3", fault_code); end
      set_lights(RED, RED, PRED);
      step(3);
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL sy_clear: got %0b want 0", fault); end
      total++; if (fault_code !== F_NONE) begin bad++; $display("FAIL sy_clear_code: got %0d want 0", fault_code); end
      total++; if (flash_en !== 1'b0) begin bad++; $display("FAIL sy_clear_flash: got %0b want 0", flash_en); end
   endtask

   task automatic test_stuck();
      exp_t e;
      set_lights(GRN, RED, PRED);
      sb.push_back('{ph: P_MG, flt: 1'b1, code: F_STUCK});
      step(3);
      step(79);
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL stuck_early: got %0b want 0", fault); end
      total++; if (sec_in_phase !== 4'd9) begin bad++; $display("FAIL stuck_sec9: got %0d want 9", sec_in_phase); end
      step(1);
      e = sb.pop_front();
      total++; if (fault !== e.flt) begin bad++; $display("FAIL stuck_fault: got %0b want %0b", fault, e.flt); end
      total++; if (fault_code !== e.code) begin bad++; $display("FAIL stuck_code: got %0d want %0d", fault_code, e.code); end
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL stuck_phase: got %0d want %0d", phase_id, e.ph); end
      step(16);
      total++; if (sec_in_phase !== 4'd10) begin bad++; $display("FAIL stuck_sat: got %0d want 10", sec_in_phase); end
      recover();
   endtask

   task automatic test_priority_reset();
      exp_t e;
      set_lights(GRN, RED, PRED);
      step(3);
      set_lights(YEL, RED, PRED);
      step(5);
      set_lights(YEL, GRN, PRED);
      sb.push_back('{ph: P_MY, flt: 1'b1, code: F_CONFLICT});
      step(3);
      e = sb.pop_front();
      total++; if (fault_code !== e.code) begin bad++; $display("FAIL prio_code: got %0d want %0d", fault_code, e.code); end
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL prio_phase: got %0d want %0d", phase_id, e.ph); end
      step(5);
      reset = 1'b1;
      #2;
      total++; if (phase_id !== P_UNSYNC) begin bad++; $display("FAIL mid_rst_phase: got %0d want 0", phase_id); end
      total++; if (sec_in_phase !== 4'd0) begin bad++; $display("FAIL mid_rst_sec: got %0d want 0", sec_in_phase); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL mid_rst_fault: got %0b want 0", fault); end
      total++; if (fault_code !== F_NONE) begin bad++; $display("FAIL mid_rst_code: got %0d want 0", fault_code); end
      total++; if (flash_en !== 1'b0) begin bad++; $display("FAIL mid_rst_flash: got %0b want 0", flash_en); end
      set_lights(GRN, RED, PRED);
      step(2);
      reset = 1'b0;
      sb.push_back('{ph: P_MG, flt: 1'b0, code: F_NONE});
      step(3);
      e = sb.pop_front();
      total++; if (phase_id !== e.ph) begin bad++; $display("FAIL resync_phase: got %0d want %0d", phase_id, e.ph); end
      step(5);
      total++; if (fault !== e.flt) begin bad++; $display("FAIL resync_fault: got %0b want %0b", fault, e.flt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_legal_cycle();
      test_conflict();
      test_bad_seq();
      test_short_yellow();
      test_stuck();
      test_priority_reset();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
